uart_tx_frame_serializer: RTL

//   UART transmit engine and the TX-side companion of the UART receiver.

---
 rtl/uart_tx_frame_serializer_if.sv | 30 +++
 rtl/uart_tx_frame_serializer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_serializer_if.sv
// Parallel-request / serial-line bundle between an upstream producer and the UART TX engine.
// The producer drives the master side; the serializer sits on the slave side.
interface uart_tx_frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit engine: start bit, LSB-first data, optional parity, stop bit, one bit per CLK.
// TX_OUT and Busy are driven straight from flops so the line never glitches on input changes.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_tx_frame_serializer_if.slave   bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_reg,   state_next;
  logic [CW-1:0]         cnt_reg,     cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg,   shift_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  par_en_reg,  par_en_next;
  logic                  tx_out_reg,  tx_out_next;
  logic                  busy_reg,    busy_next;

  logic [DATA_WIDTH-1:0] shift_dn;
  logic                  accept_par_bit;

  // Shift register moves toward bit 0, so the next bit to send is always shift_reg[0].
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
    if (gi == DATA_WIDTH - 1) begin : g_top
      assign shift_dn[gi] = 1'b0;
    end else begin : g_body
      assign shift_dn[gi] = shift_reg[gi+1];
    end
  end

  assign accept_par_bit = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      par_bit_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      tx_out_reg  <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      par_bit_reg <= par_bit_next;
      par_en_reg  <= par_en_next;
      tx_out_reg  <= tx_out_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    par_bit_next = par_bit_reg;
    par_en_next  = par_en_reg;
    tx_out_next  = tx_out_reg;
    busy_next    = busy_reg;

    case (state_reg)
      IDLE: begin
        tx_out_next = 1'b1;
        busy_next   = 1'b0;
        if (bus.Data_Valid) begin
          state_next   = START;
          shift_next   = bus.P_DATA;
          par_bit_next = accept_par_bit;
          par_en_next  = bus.PAR_EN;
          tx_out_next  = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        state_next  = DATA;
        cnt_next    = '0;
        tx_out_next = shift_reg[0];
        shift_next  = shift_dn;
        busy_next   = 1'b1;
      end
      DATA: begin
        cnt_next  = cnt_reg + CW'(1);
        busy_next = 1'b1;
        if (cnt_reg == CW'(DATA_WIDTH - 1)) begin
          if (par_en_reg) begin
            state_next  = PARITY;
            tx_out_next = par_bit_reg;
          end else begin
            state_next  = STOP;
            tx_out_next = 1'b1;
          end
        end else begin
          tx_out_next = shift_reg[0];
          shift_next  = shift_dn;
        end
      end
      PARITY: begin
        state_next  = STOP;
        tx_out_next = 1'b1;
        busy_next   = 1'b1;
      end
      STOP: begin
        // A request waiting at the end of the stop bit chains straight into the next start bit.
        if (bus.Data_Valid) begin
          state_next   = START;
          shift_next   = bus.P_DATA;
          par_bit_next = accept_par_bit;
          par_en_next  = bus.PAR_EN;
          tx_out_next  = 1'b0;
          busy_next    = 1'b1;
        end else begin
          state_next  = IDLE;
          tx_out_next = 1'b1;
          busy_next   = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        tx_out_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx_out_reg;
  assign bus.Busy   = busy_reg;

endmodule
